// File: rtl/sha256_msg_ingest.sv
// -----------------------------------------------------------------------------
// sha256_msg_ingest
//
// Front end of the SHA-256 datapath. Message words arrive from the register
// interface one at a time through a software-toggled strobe. They are collected
// into a 16-word buffer and padded: a 0x80 byte follows the message, then zero
// fill, then a 64-bit big-endian bit length. Finished 512-bit blocks go out on a
// valid/ready stream to the compression core.
//
// Ports
//   axi_clk_i      : clock, rising edge
//   aresetn_i      : asynchronous active-low reset
//   ctrl_signals   : [31] word strobe (level), [30] last word, [3:0] byte keep
//   string_i       : message word, first byte in [31:24]
//   block_o        : padded block, word 0 in [511:480], word 15 in [31:0]
//   block_valid_o  : block_o holds a block for downstream
//   block_ready_i  : downstream accepts the block on this edge
//   block_last_o   : the presented block ends the message
//   busy_o         : a block is pending, software must not commit
//   error_o        : sticky; commit while busy or illegal keep
// -----------------------------------------------------------------------------
module sha256_msg_ingest (
  input  logic         axi_clk_i,
  input  logic         aresetn_i,
  input  logic [31:0]  ctrl_signals,
  input  logic [31:0]  string_i,
  output logic [511:0] block_o,
  output logic         block_valid_o,
  input  logic         block_ready_i,
  output logic         block_last_o,
  output logic         busy_o,
  output logic         error_o
);

  // Bit-length field width, fixed by SHA-256.
  localparam int LEN_W = 64;

  typedef enum logic [1:0] {
    COLLECT, // accepting message words
    FULL,    // 16 data words ready, more message follows
    EXTRA1,  // padding did not leave room for the length; length block follows
    LAST     // final block of the message
  } state_t;

  state_t state, state_nxt;

  logic [31:0] words [16];
  logic [3:0]  idx;
  logic [60:0] byte_cnt;    // bit length is byte_cnt * 8, wraps modulo 2^61
  logic        strobe_q;
  logic        armed;       // strobe has been seen low since reset
  logic        pad_carry;   // 0x80 byte spilled past word 15 into the extra block
  logic        error_q;

  // Control bits that carry no meaning here.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_signals[29:4];

  // ---------------------------------------------------------------------------
  // Commit detection and last-word decode
  // ---------------------------------------------------------------------------
  logic             strobe, is_last, commit, take;
  logic [3:0]       keep;
  logic [2:0]       nbytes;
  logic             keep_legal;
  logic [31:0]      last_word;
  logic [4:0]       pad_idx;
  logic             fits;
  logic [60:0]      new_cnt;
  logic [LEN_W-1:0] len_new, len_cur;

  assign strobe  = ctrl_signals[31];
  assign is_last = ctrl_signals[30];
  assign keep    = ctrl_signals[3:0];

  // A strobe already high when reset releases must drop once before it counts.
  assign commit = strobe & ~strobe_q & armed;
  assign take   = commit & (state == COLLECT);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    nbytes     = 3'd4;
    keep_legal = 1'b1;
    case (keep)
      4'b1111: nbytes = 3'd4;
      4'b1110: nbytes = 3'd3;
      4'b1100: nbytes = 3'd2;
      4'b1000: nbytes = 3'd1;
      4'b0000: nbytes = 3'd0;
      default: keep_legal = 1'b0; // treated as a full word
    endcase
  end

  // Valid bytes are MSB-aligned; 0x80 lands right after them, the rest is zero.
  always_comb begin
    last_word = string_i;
    case (nbytes)
      3'd3:    last_word = {string_i[31:8], 8'h80};
      3'd2:    last_word = {string_i[31:16], 16'h8000};
      3'd1:    last_word = {string_i[31:24], 24'h80_0000};
      3'd0:    last_word = 32'h8000_0000;
      default: last_word = string_i;
    endcase
  end

  // Index of the word that receives the 0x80 byte (16 means "next block").
  assign pad_idx = {1'b0, idx} + {4'd0, (nbytes == 3'd4)};
  assign fits    = (pad_idx <= 5'd13);
  assign new_cnt = byte_cnt + {58'd0, nbytes};
  assign len_new = {new_cnt, 3'b000};
  assign len_cur = {byte_cnt, 3'b000};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge axi_clk_i or negedge aresetn_i) begin
    if (!aresetn_i) state <= COLLECT;
    else            state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (take) begin
          if (is_last)          state_nxt = fits ? LAST : EXTRA1;
          else if (idx == 4'd15) state_nxt = FULL;
        end
      end
      FULL:    if (block_ready_i) state_nxt = COLLECT;
      EXTRA1:  if (block_ready_i) state_nxt = LAST;
      LAST:    if (block_ready_i) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    block_valid_o = (state != COLLECT);
    block_last_o  = (state == LAST);
    busy_o        = (state != COLLECT);
    block_o       = '0;
    for (int i = 0; i < 16; i++) block_o[511 - 32*i -: 32] = words[i];
  end

  assign error_o = error_q;

  // ---------------------------------------------------------------------------
  // Datapath: word buffer, counters, strobe history, error flag
  // ---------------------------------------------------------------------------
  // NOTE: the word buffer is reset because its contents drive block_o, which
  // must read zero out of reset; it is also cleared after every block so unused
  // words are already zero when padding is applied.
  always_ff @(posedge axi_clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < 16; i++) words[i] <= '0;
      idx       <= '0;
      byte_cnt  <= '0;
      strobe_q  <= 1'b0;
      armed     <= 1'b0;
      pad_carry <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      strobe_q <= strobe;
      if (!strobe) armed <= 1'b1;

      // Commits while a block is pending are dropped and flagged.
      if (commit && state != COLLECT)      error_q <= 1'b1;
      if (take && is_last && !keep_legal)  error_q <= 1'b1;

      case (state)
        COLLECT: begin
          if (take) begin
            if (!is_last) begin
              words[idx] <= string_i;
              idx        <= idx + 4'd1;
              byte_cnt   <= byte_cnt + 61'd4;
            end else begin
              words[idx] <= last_word;
              // Full last word: 0x80 starts the following word, if one exists here.
              if (nbytes == 3'd4 && idx != 4'd15) words[idx + 4'd1] <= 32'h8000_0000;
              pad_carry  <= (nbytes == 3'd4) && (idx == 4'd15);
              byte_cnt   <= new_cnt;
              if (fits) begin
                words[14] <= len_new[63:32];
                words[15] <= len_new[31:0];
              end
            end
          end
        end
        FULL: begin
          if (block_ready_i) begin
            for (int i = 0; i < 16; i++) words[i] <= '0;
            idx <= '0;
          end
        end
        EXTRA1: begin
          // Length-only block, carrying the 0x80 byte if it overflowed word 15.
          if (block_ready_i) begin
            for (int i = 0; i < 16; i++) words[i] <= '0;
            words[0]  <= pad_carry ? 32'h8000_0000 : 32'h0;
            words[14] <= len_cur[63:32];
            words[15] <= len_cur[31:0];
            pad_carry <= 1'b0;
          end
        end
        LAST: begin
          if (block_ready_i) begin
            for (int i = 0; i < 16; i++) words[i] <= '0;
            idx      <= '0;
            byte_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_ingest.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_ingest
//
// Self-checking bench for sha256_msg_ingest. Expected blocks come from a
// byte-level FIPS 180-4 padding model and sit in a scoreboard queue until the
// DUT transfers a block. A table of messages covers the main length
// boundaries; hand-written sequences cover backpressure, overrun, held strobe,
// illegal keep and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_sha256_msg_ingest;

  logic         axi_clk_i = 1'b0;
  logic         aresetn_i;
  logic [31:0]  ctrl_signals;
  logic [31:0]  string_i;
  logic [511:0] block_o;
  logic         block_valid_o;
  logic         block_ready_i;
  logic         block_last_o;
  logic         busy_o;
  logic         error_o;

  sha256_msg_ingest dut (
    .axi_clk_i     (axi_clk_i),
    .aresetn_i     (aresetn_i),
    .ctrl_signals  (ctrl_signals),
    .string_i      (string_i),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .block_ready_i (block_ready_i),
    .block_last_o  (block_last_o),
    .busy_o        (busy_o),
    .error_o       (error_o)
  );

  always #5 axi_clk_i = ~axi_clk_i;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } blk_t;

  typedef struct {
    string       name;
    int          n_full;
    logic [31:0] lw;
    logic [3:0]  keep;
    int          nblk;
    logic [31:0] w15;
  } vec_t;

  blk_t        sb[$];
  blk_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int          rx_cnt = 0;
  logic [31:0] last_w15 = '0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: sample half a cycle before the transfer edge.
  always @(negedge axi_clk_i) begin
    if (aresetn_i && block_valid_o && block_ready_i) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_block: got %0h want none", block_o);
      end else begin
        mon_e = sb.pop_front();
        check("blk_data", block_o, mon_e.data);
        check("blk_last", {511'd0, block_last_o}, {511'd0, mon_e.last});
      end
      rx_cnt++;
      last_w15 = block_o[31:0];
    end
  end

  function automatic int keep_bytes(input logic [3:0] k);
    case (k)
      4'b1111: return 4;
      4'b1110: return 3;
      4'b1100: return 2;
      4'b1000: return 1;
      4'b0000: return 0;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] word_of(input int i);
    return {8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3), 8'(4*i + 4)};
  endfunction

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit length.
  task automatic push_expected(input byte unsigned m[$]);
    byte unsigned   p[$];
    longint unsigned bits;
    blk_t           b;
    int             nblk;
    p    = m;
    bits = 64'(m.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8*i)));
    nblk = p.size() / 64;
    for (int bi = 0; bi < nblk; bi++) begin
      b.data = '0;
      for (int j = 0; j < 64; j++) b.data[511 - 8*j -: 8] = p[bi*64 + j];
      b.last = (bi == nblk - 1);
      sb.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 two edges later.
  // v is block_valid_o one step after the commit edge.
  task automatic commit(input logic [31:0] w, input logic last, input logic [3:0] keep,
                        output logic v);
    string_i     = w;
    ctrl_signals = {1'b1, last, 26'd0, keep};
    @(posedge axi_clk_i); #1;
    v = block_valid_o;
    ctrl_signals[31] = 1'b0;
    @(posedge axi_clk_i); #1;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy_o && n < 200) begin
      @(posedge axi_clk_i); #1;
      n++;
    end
    if (busy_o) check("busy_timeout", {511'd0, busy_o}, 512'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < 300) begin
      @(posedge axi_clk_i); #1;
      n++;
    end
    check("drain_sb", 512'(sb.size()), 512'd0);
  endtask

  task automatic run_msg(input string name, input int n_full, input logic [31:0] lw,
                         input logic [3:0] keep, input int nblk, input logic [31:0] w15,
                         input logic exp_err);
    byte unsigned m[$];
    logic         v;
    for (int i = 0; i < n_full; i++) begin
      for (int j = 0; j < 4; j++) m.push_back(8'(4*i + j + 1));
    end
    for (int j = 0; j < keep_bytes(keep); j++) m.push_back(lw[31 - 8*j -: 8]);
    push_expected(m);
    rx_cnt = 0;
    for (int i = 0; i < n_full; i++) begin
      wait_not_busy();
      commit(word_of(i), 1'b0, 4'b0101, v); // keep is ignored on non-last words
    end
    wait_not_busy();
    commit(lw, 1'b1, keep, v);
    wait_drain();
    check($sformatf("%s_nblk", name), 512'(rx_cnt), 512'(nblk));
    check($sformatf("%s_w15", name), {480'd0, last_w15}, {480'd0, w15});
    check($sformatf("%s_err", name), {511'd0, error_o}, {511'd0, exp_err});
  endtask

  task automatic do_reset();
    aresetn_i = 1'b0;
    sb.delete();
    repeat (2) @(posedge axi_clk_i);
    #1;
    aresetn_i = 1'b1;
    @(posedge axi_clk_i); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[10];
    logic        v;
    logic        ok;
    byte unsigned hm[$];

    vt[0] = '{"abc",       0,  32'h6162_6330, 4'b1110, 1, 32'h0000_0018};
    vt[1] = '{"len55",     13, 32'hA1A2_A3A4, 4'b1110, 1, 32'h0000_01B8};
    vt[2] = '{"len56",     13, 32'hB1B2_B3B4, 4'b1111, 2, 32'h0000_01C0};
    vt[3] = '{"len64_k0",  16, 32'hC1C2_C3C4, 4'b0000, 2, 32'h0000_0200};
    vt[4] = '{"len64_k4",  15, 32'hD1D2_D3D4, 4'b1111, 2, 32'h0000_0200};
    vt[5] = '{"empty",     0,  32'hE1E2_E3E4, 4'b0000, 1, 32'h0000_0000};
    vt[6] = '{"len9",      2,  32'hF1F2_F3F4, 4'b1000, 1, 32'h0000_0048};
    vt[7] = '{"len52",     12, 32'h9192_9394, 4'b1111, 1, 32'h0000_01A0};
    vt[8] = '{"len54",     13, 32'h8182_8384, 4'b1100, 1, 32'h0000_01B0};
    vt[9] = '{"len81",     20, 32'h7172_7374, 4'b1000, 2, 32'h0000_0288};

    // Reset with the strobe already high: it must not commit on release.
    aresetn_i     = 1'b0;
    block_ready_i = 1'b1;
    string_i      = 32'hCAFE_F00D;
    ctrl_signals  = {1'b1, 1'b1, 26'd0, 4'b1111};
    repeat (3) @(posedge axi_clk_i);
    #1;
    check("rst_block", block_o, 512'd0);
    check("rst_valid", {511'd0, block_valid_o}, 512'd0);
    check("rst_last",  {511'd0, block_last_o},  512'd0);
    check("rst_busy",  {511'd0, busy_o},        512'd0);
    check("rst_error", {511'd0, error_o},       512'd0);
    aresetn_i = 1'b1;
    repeat (3) @(posedge axi_clk_i);
    #1;
    check("held_at_release_valid", {511'd0, block_valid_o}, 512'd0);
    ctrl_signals[31] = 1'b0;
    @(posedge axi_clk_i); #1;

    // "abc" under backpressure: latency, content, stability, overrun.
    block_ready_i = 1'b0;
    hm = '{8'h61, 8'h62, 8'h63};
    push_expected(hm);
    rx_cnt = 0;
    commit(32'h6162_6330, 1'b1, 4'b1110, v);
    check("abc_latency", {511'd0, v}, {511'd0, 1'b1});
    check("abc_w0",  {480'd0, block_o[511:480]}, {480'd0, 32'h6162_6380});
    check("abc_w15", {480'd0, block_o[31:0]},    {480'd0, 32'h0000_0018});
    check("abc_mid", {64'd0, block_o[479:32]},   512'd0);
    check("abc_last", {511'd0, block_last_o}, {511'd0, 1'b1});
    ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge axi_clk_i); #1;
      if (block_o !== sb[0].data || busy_o !== 1'b1 || block_valid_o !== 1'b1) ok = 1'b0;
    end
    check("bp_stable", {511'd0, ok}, {511'd0, 1'b1});
    check("pre_overrun_err", {511'd0, error_o}, 512'd0);
    commit(32'h1111_1111, 1'b0, 4'b1111, v);
    check("overrun_err",   {511'd0, error_o}, {511'd0, 1'b1});
    check("overrun_block", block_o, sb[0].data);
    check("overrun_valid", {511'd0, block_valid_o}, {511'd0, 1'b1});
    block_ready_i = 1'b1;
    wait_drain();
    check("bp_nblk", 512'(rx_cnt), 512'd1);

    do_reset();
    check("err_cleared", {511'd0, error_o}, 512'd0);

    // Held strobe level commits exactly one word.
    hm = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_expected(hm);
    rx_cnt       = 0;
    string_i     = 32'hDEAD_BEEF;
    ctrl_signals = {1'b1, 1'b0, 26'd0, 4'b1111};
    repeat (10) @(posedge axi_clk_i);
    #1;
    ctrl_signals[31] = 1'b0;
    @(posedge axi_clk_i); #1;
    commit(32'h0, 1'b1, 4'b0000, v);
    wait_drain();
    check("held_nblk", 512'(rx_cnt), 512'd1);
    check("held_w15", {480'd0, last_w15}, {480'd0, 32'h0000_0020});

    // Table of message lengths around the padding boundaries.
    for (int i = 0; i < 10; i++)
      run_msg(vt[i].name, vt[i].n_full, vt[i].lw, vt[i].keep, vt[i].nblk, vt[i].w15, 1'b0);

    // Illegal keep: flagged and treated as a full word.
    run_msg("bad_keep", 1, 32'h1122_3344, 4'b1010, 1, 32'h0000_0040, 1'b1);

    // Asynchronous reset while LAST is pending.
    do_reset();
    block_ready_i = 1'b0;
    hm = '{8'h61, 8'h62, 8'h63};
    push_expected(hm);
    commit(32'h6162_6330, 1'b1, 4'b1110, v);
    check("pre_abort_valid", {511'd0, block_valid_o}, {511'd0, 1'b1});
    #3;
    aresetn_i = 1'b0;
    #1;
    check("abort_block", block_o, 512'd0);
    check("abort_valid", {511'd0, block_valid_o}, 512'd0);
    check("abort_last",  {511'd0, block_last_o},  512'd0);
    check("abort_busy",  {511'd0, busy_o},        512'd0);
    sb.delete();
    @(posedge axi_clk_i); #1;
    aresetn_i     = 1'b1;
    block_ready_i = 1'b1;
    @(posedge axi_clk_i); #1;
    run_msg("abc_after_abort", 0, 32'h6162_6330, 4'b1110, 1, 32'h0000_0018, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
